// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter: shares the cartridge memory port between the GB bus (strict priority) and the AVR loader.
module cart_mem_arbiter #(
  parameter int ADDR_W     = 21,
  parameter int ACC_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gb_rd_n,
  input  logic              gb_wr_n,
  input  logic [ADDR_W-1:0] gb_addr,
  input  logic [7:0]        gb_wdata,
  output logic [7:0]        gb_rdata,
  output logic              gb_dout_oe,
  output logic              gb_ovr,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_wdata,
  output logic              ld_ack,
  output logic [7:0]        ld_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              mem_oe,
  output logic              mem_we,
  output logic              busy
);
  localparam logic [1:0] IDLE = 2'd0, GB_ACC = 2'd1, LD_ACC = 2'd2;
  logic [1:0] state;
  logic [2:0] cnt;
  logic rd_s1, rd_s2, wr_s1, wr_s2, idle_q;
  logic gb_pend, gb_we, gb_rvalid, ld_we_q;
  logic [ADDR_W-1:0] gb_a, ld_a;
  logic [7:0] gb_d, ld_d;
  logic last, gb_evt, gb_done, ld_done;
  assign last    = cnt == 3'(ACC_CYCLES - 1);
  assign gb_evt  = idle_q & ~(rd_s2 & wr_s2);
  assign gb_done = (state == GB_ACC) & last;
  assign ld_done = (state == LD_ACC) & last;
  assign busy       = state != IDLE;
  assign gb_dout_oe = gb_rvalid & ~rd_s2;
  assign mem_addr   = state == GB_ACC ? gb_a : state == LD_ACC ? ld_a : '0;
  assign mem_wdata  = state == GB_ACC ? gb_d : state == LD_ACC ? ld_d : '0;
  assign mem_we     = ((state == GB_ACC) & gb_we) | ((state == LD_ACC) & ld_we_q);
  assign mem_oe     = ((state == GB_ACC) & ~gb_we) | ((state == LD_ACC) & ~ld_we_q);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {rd_s2, rd_s1, wr_s2, wr_s1, idle_q} <= 5'b11111;
      state     <= IDLE;
      cnt       <= 3'd0;
      gb_pend   <= 1'b0;
      gb_ovr    <= 1'b0;
      gb_we     <= 1'b0;
      gb_a      <= '0;
      gb_d      <= 8'd0;
      gb_rdata  <= 8'd0;
      gb_rvalid <= 1'b0;
      ld_we_q   <= 1'b0;
      ld_a      <= '0;
      ld_d      <= 8'd0;
      ld_ack    <= 1'b0;
      ld_rdata  <= 8'd0;
    end else begin
      {rd_s2, rd_s1} <= {rd_s1, gb_rd_n};
      {wr_s2, wr_s1} <= {wr_s1, gb_wr_n};
      idle_q         <= rd_s2 & wr_s2;
      // a pending flag being cleared this cycle frees the slot for a new event
      if (gb_evt && gb_pend && !gb_done) gb_ovr <= 1'b1;
      else if (gb_evt) begin
        gb_pend <= 1'b1;
        gb_a    <= gb_addr;
        gb_d    <= gb_wdata;
        gb_we   <= ~wr_s2;
      end else if (gb_done) gb_pend <= 1'b0;
      if (gb_done && !gb_we) gb_rdata <= mem_rdata;
      gb_rvalid <= rd_s2 ? 1'b0 : (gb_done & ~gb_we) | gb_rvalid;
      ld_ack    <= ld_done;
      if (ld_done && !ld_we_q) ld_rdata <= mem_rdata;
      cnt <= (state != IDLE && !last) ? cnt + 3'd1 : 3'd0;
      // a request still high in the ack cycle waits one cycle before being served
      if (state == IDLE) begin
        if (gb_pend) state <= GB_ACC;
        else if (ld_req && !ld_ack) begin
          state   <= LD_ACC;
          ld_a    <= ld_addr;
          ld_d    <= ld_wdata;
          ld_we_q <= ld_we;
        end
      end else if (last) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_cart_mem_arbiter.sv
// tb_cart_mem_arbiter: directed checks of priority, timing, overrun and reset of cart_mem_arbiter.
module tb_cart_mem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        gb_rd_n = 1'b1, gb_wr_n = 1'b1;
  logic [20:0] gb_addr = '0, ld_addr = '0;
  logic [7:0]  gb_wdata = '0, ld_wdata = '0, mem_rdata = '0;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [7:0]  gb_rdata, ld_rdata, mem_wdata;
  logic        gb_dout_oe, gb_ovr, ld_ack, mem_oe, mem_we, busy;
  logic [20:0] mem_addr;
  int total = 0, passed = 0;

  cart_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .gb_rd_n(gb_rd_n), .gb_wr_n(gb_wr_n),
    .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_rdata(gb_rdata),
    .gb_dout_oe(gb_dout_oe), .gb_ovr(gb_ovr), .ld_req(ld_req), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_oe(mem_oe), .mem_we(mem_we), .busy(busy)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_mem_oe", 32'(mem_oe), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ld_ack", 32'(ld_ack), 0);
    chk("rst_dout_oe", 32'(gb_dout_oe), 0);
    chk("rst_ovr", 32'(gb_ovr), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_gb_rdata", 32'(gb_rdata), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    // 1: GB read
    gb_addr = 21'h04000; mem_rdata = 8'h5A; gb_rd_n = 1'b0;
    repeat (3) tick();
    chk("t1_idle_before", 32'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_mem_oe", 32'(mem_oe), 1);
      chk("t1_mem_we", 32'(mem_we), 0);
      chk("t1_mem_addr", 32'(mem_addr), 32'h04000);
    end
    tick();
    chk("t1_oe_end", 32'(mem_oe), 0);
    chk("t1_dout_oe", 32'(gb_dout_oe), 1);
    chk("t1_gb_rdata", 32'(gb_rdata), 32'h5A);
    gb_rd_n = 1'b1;
    tick();
    chk("t1_dout_hold", 32'(gb_dout_oe), 1);
    tick();
    chk("t1_dout_drop", 32'(gb_dout_oe), 0);
    tick();
    // 2: loader write at top address
    ld_we = 1'b1; ld_addr = 21'h1FFFFF; ld_wdata = 8'hC3; ld_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_mem_we", 32'(mem_we), 1);
      chk("t2_mem_oe", 32'(mem_oe), 0);
      chk("t2_mem_addr", 32'(mem_addr), 32'h1FFFFF);
      chk("t2_mem_wdata", 32'(mem_wdata), 32'hC3);
      chk("t2_no_ack", 32'(ld_ack), 0);
    end
    tick();
    chk("t2_ack", 32'(ld_ack), 1);
    chk("t2_we_end", 32'(mem_we), 0);
    ld_req = 1'b0;
    tick();
    chk("t2_ack_pulse", 32'(ld_ack), 0);
    chk("t2_busy", 32'(busy), 0);
    // 3: GB write and loader read contend in the same idle cycle
    gb_addr = 21'h00123; gb_wdata = 8'h77; gb_wr_n = 1'b0;
    ld_we = 1'b0; ld_addr = 21'h0ABCD; mem_rdata = 8'h3C;
    repeat (3) tick();
    chk("t3_idle", 32'(busy), 0);
    ld_req = 1'b1; gb_wr_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_gb_we", 32'(mem_we), 1);
      chk("t3_gb_addr", 32'(mem_addr), 32'h00123);
      chk("t3_gb_wdata", 32'(mem_wdata), 32'h77);
    end
    tick();
    chk("t3_gap", 32'(busy), 0);
    chk("t3_gap_ack", 32'(ld_ack), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_ld_oe", 32'(mem_oe), 1);
      chk("t3_ld_addr", 32'(mem_addr), 32'h0ABCD);
    end
    tick();
    chk("t3_ack", 32'(ld_ack), 1);
    chk("t3_ld_rdata", 32'(ld_rdata), 32'h3C);
    chk("t3_ovr", 32'(gb_ovr), 0);
    chk("t3_no_dout", 32'(gb_dout_oe), 0);
    ld_req = 1'b0;
    tick();
    // 4: GB read arrives one cycle into a loader read
    ld_we = 1'b0; ld_addr = 21'h00042; mem_rdata = 8'h99; ld_req = 1'b1;
    tick();
    chk("t4_ld_oe", 32'(mem_oe), 1);
    chk("t4_ld_addr0", 32'(mem_addr), 32'h00042);
    gb_addr = 21'h04001; gb_rd_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_ld_addr", 32'(mem_addr), 32'h00042);
    end
    tick();
    chk("t4_ack", 32'(ld_ack), 1);
    chk("t4_ld_rdata", 32'(ld_rdata), 32'h99);
    chk("t4_gap", 32'(busy), 0);
    ld_req = 1'b0; mem_rdata = 8'h66;
    tick();
    chk("t4_gb_addr", 32'(mem_addr), 32'h04001);
    chk("t4_gb_oe", 32'(mem_oe), 1);
    repeat (3) tick();
    chk("t4_no_dout_yet", 32'(gb_dout_oe), 0);
    tick();
    chk("t4_dout_oe", 32'(gb_dout_oe), 1);
    chk("t4_gb_rdata", 32'(gb_rdata), 32'h66);
    gb_rd_n = 1'b1;
    repeat (3) tick();
    // 5: second strobe fall while the first is still pending
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 21'h00010;
    gb_addr = 21'h04002; gb_rd_n = 1'b0;
    tick();
    gb_rd_n = 1'b1;
    tick();
    gb_rd_n = 1'b0;
    tick();
    chk("t5_ovr_first", 32'(gb_ovr), 0);
    tick();
    chk("t5_ovr_before", 32'(gb_ovr), 0);
    tick();
    chk("t5_ovr_set", 32'(gb_ovr), 1);
    chk("t5_ack", 32'(ld_ack), 1);
    ld_req = 1'b0;
    repeat (5) tick();
    chk("t5_dout_oe", 32'(gb_dout_oe), 1);
    chk("t5_ovr_sticky", 32'(gb_ovr), 1);
    gb_rd_n = 1'b1;
    repeat (3) tick();
    chk("t5_ovr_idle", 32'(gb_ovr), 1);
    // 6: reset during cycle 2 of a loader write
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 21'h00055; ld_wdata = 8'hAA;
    tick();
    chk("t6_we_c1", 32'(mem_we), 1);
    tick();
    chk("t6_we_c2", 32'(mem_we), 1);
    rst_n = 1'b0;
    tick();
    chk("t6_we_drop", 32'(mem_we), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_no_ack", 32'(ld_ack), 0);
    chk("t6_ovr_clr", 32'(gb_ovr), 0);
    ld_req = 1'b0;
    tick();
    chk("t6_no_ack2", 32'(ld_ack), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("t6_idle", 32'(busy), 0);
    chk("t6_no_ack3", 32'(ld_ack), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
